// File: rtl/op_lut_event_cntr_regs.sv
// Per-event counters with overflow flags, read and written over the register ring.
// Claimed ring requests are answered in place with a fixed one-cycle ring latency.
module op_lut_event_cntr_regs #(
  parameter int unsigned NUM_EVENTS        = 10,
  parameter int unsigned CNTR_WIDTH        = 32,
  parameter bit          SATURATE          = 1'b0,
  parameter bit          CLEAR_ON_READ     = 1'b1,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned REG_ADDR_WIDTH    = 23,
  parameter int unsigned UDP_REG_SRC_WIDTH = 2,
  parameter int unsigned BLOCK_TAG         = 'h1,
  parameter int unsigned IDX_WIDTH         = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         reg_req_in,
  input  logic                         reg_ack_in,
  input  logic                         reg_rd_wr_L_in,
  input  logic [REG_ADDR_WIDTH-1:0]    reg_addr_in,
  input  logic [DATA_WIDTH-1:0]        reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,
  output logic                         reg_req_out,
  output logic                         reg_ack_out,
  output logic                         reg_rd_wr_L_out,
  output logic [REG_ADDR_WIDTH-1:0]    reg_addr_out,
  output logic [DATA_WIDTH-1:0]        reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,
  input  logic [NUM_EVENTS-1:0]        events,
  output logic [NUM_EVENTS-1:0]        overflow
);

  localparam int unsigned TAG_WIDTH = REG_ADDR_WIDTH - IDX_WIDTH;
  localparam logic [CNTR_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [31:0] BAD_IDX_DATA = 32'hDEAD_BEEF;

  logic                         claimed;
  logic                         idx_valid;
  logic [IDX_WIDTH-1:0]         idx;
  logic [NUM_EVENTS-1:0]        hit;
  logic [CNTR_WIDTH-1:0]        rd_val;
  logic [CNTR_WIDTH-1:0]        cnt   [NUM_EVENTS];
  logic [CNTR_WIDTH-1:0]        cnt_d [NUM_EVENTS];
  logic [NUM_EVENTS-1:0]        ovf_d;
  logic                         req_d, ack_d, rd_d;
  logic [REG_ADDR_WIDTH-1:0]    addr_d;
  logic [DATA_WIDTH-1:0]        data_d;
  logic [UDP_REG_SRC_WIDTH-1:0] src_d;

  assign idx = reg_addr_in[IDX_WIDTH-1:0];

  // Address decode and read mux over the pre-increment counter values
  always_comb begin
    claimed   = reg_req_in && !reg_ack_in &&
                (reg_addr_in[REG_ADDR_WIDTH-1:IDX_WIDTH] == TAG_WIDTH'(BLOCK_TAG));
    idx_valid = 32'(idx) < NUM_EVENTS;
    hit       = '0;
    rd_val    = '0;
    for (int i = 0; i < int'(NUM_EVENTS); i++) begin
      hit[i] = claimed && (idx == IDX_WIDTH'(i));
      if (hit[i]) rd_val = cnt[i];
    end
  end

  // Counter update: load beats event; clear-on-read happens before the event adds
  always_comb begin
    logic [CNTR_WIDTH-1:0] base;
    logic                  load;
    logic                  rd_clr;
    base   = '0;
    load   = 1'b0;
    rd_clr = 1'b0;
    ovf_d  = overflow;
    for (int i = 0; i < int'(NUM_EVENTS); i++) begin
      load     = hit[i] && !reg_rd_wr_L_in;
      rd_clr   = hit[i] && reg_rd_wr_L_in && CLEAR_ON_READ;
      base     = load ? CNTR_WIDTH'(reg_data_in) : (rd_clr ? '0 : cnt[i]);
      cnt_d[i] = base;
      ovf_d[i] = overflow[i] && !(load || rd_clr);
      if (events[i] && !load) begin
        if (base == CNT_MAX) begin
          cnt_d[i] = SATURATE ? CNT_MAX : '0;
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = base + CNTR_WIDTH'(1);
          if (SATURATE && (base + CNTR_WIDTH'(1) == CNT_MAX)) ovf_d[i] = 1'b1;
        end
      end
    end
  end

  // Ring pass-through with in-place answer for claimed requests
  always_comb begin
    req_d  = reg_req_in;
    ack_d  = reg_ack_in | claimed;
    rd_d   = reg_rd_wr_L_in;
    addr_d = reg_addr_in;
    src_d  = reg_src_in;
    data_d = reg_data_in;
    if (claimed && reg_rd_wr_L_in)
      data_d = idx_valid ? DATA_WIDTH'(rd_val) : DATA_WIDTH'(BAD_IDX_DATA);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
      overflow        <= '0;
      for (int i = 0; i < int'(NUM_EVENTS); i++) cnt[i] <= '0;
    end else begin
      reg_req_out     <= req_d;
      reg_ack_out     <= ack_d;
      reg_rd_wr_L_out <= rd_d;
      reg_addr_out    <= addr_d;
      reg_data_out    <= data_d;
      reg_src_out     <= src_d;
      overflow        <= ovf_d;
      for (int i = 0; i < int'(NUM_EVENTS); i++) cnt[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_op_lut_event_cntr_regs.sv
// Bench for op_lut_event_cntr_regs: a 32-bit wrapping, a 4-bit wrapping and a 4-bit
// saturating instance share one stimulus stream and are checked against a behavioural model.
module tb_op_lut_event_cntr_regs;

  localparam int unsigned NE = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 23;
  localparam int unsigned SW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_in = 1'b0, ack_in = 1'b0, rd_in = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] data_in = '0;
  logic [SW-1:0] src_in = '0;
  logic [NE-1:0] ev = '0;

  logic [2:0]    d_req, d_ack, d_rd;
  logic [AW-1:0] d_addr [3];
  logic [DW-1:0] d_data [3];
  logic [SW-1:0] d_src  [3];
  logic [NE-1:0] d_ovf  [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  op_lut_event_cntr_regs #(.CNTR_WIDTH(32), .SATURATE(1'b0)) u_w32 (
    .clk(clk), .reset(reset),
    .reg_req_in(req_in), .reg_ack_in(ack_in), .reg_rd_wr_L_in(rd_in),
    .reg_addr_in(addr_in), .reg_data_in(data_in), .reg_src_in(src_in),
    .reg_req_out(d_req[0]), .reg_ack_out(d_ack[0]), .reg_rd_wr_L_out(d_rd[0]),
    .reg_addr_out(d_addr[0]), .reg_data_out(d_data[0]), .reg_src_out(d_src[0]),
    .events(ev), .overflow(d_ovf[0]));

  op_lut_event_cntr_regs #(.CNTR_WIDTH(4), .SATURATE(1'b0)) u_w4 (
    .clk(clk), .reset(reset),
    .reg_req_in(req_in), .reg_ack_in(ack_in), .reg_rd_wr_L_in(rd_in),
    .reg_addr_in(addr_in), .reg_data_in(data_in), .reg_src_in(src_in),
    .reg_req_out(d_req[1]), .reg_ack_out(d_ack[1]), .reg_rd_wr_L_out(d_rd[1]),
    .reg_addr_out(d_addr[1]), .reg_data_out(d_data[1]), .reg_src_out(d_src[1]),
    .events(ev), .overflow(d_ovf[1]));

  op_lut_event_cntr_regs #(.CNTR_WIDTH(4), .SATURATE(1'b1)) u_s4 (
    .clk(clk), .reset(reset),
    .reg_req_in(req_in), .reg_ack_in(ack_in), .reg_rd_wr_L_in(rd_in),
    .reg_addr_in(addr_in), .reg_data_in(data_in), .reg_src_in(src_in),
    .reg_req_out(d_req[2]), .reg_ack_out(d_ack[2]), .reg_rd_wr_L_out(d_rd[2]),
    .reg_addr_out(d_addr[2]), .reg_data_out(d_data[2]), .reg_src_out(d_src[2]),
    .events(ev), .overflow(d_ovf[2]));

  function automatic longint unsigned mask_of(int k);
    return (k == 0) ? 64'hFFFF_FFFF : 64'hF;
  endfunction

  function automatic bit sat_of(int k);
    return k == 2;
  endfunction

  // Behavioural model: counters as plain integers, limited by each instance's range
  longint unsigned m_cnt [3][NE];
  bit              m_ovf [3][NE];
  bit              e_req, e_ack, e_rd;
  bit [AW-1:0]     e_addr;
  bit [DW-1:0]     e_data [3];
  bit [SW-1:0]     e_src;

  always @(posedge clk or negedge reset) begin : model
    bit              claimed;
    int              idx;
    longint unsigned nxt;
    if (!reset) begin
      e_req = 0; e_ack = 0; e_rd = 0; e_addr = '0; e_src = '0;
      for (int k = 0; k < 3; k++) begin
        e_data[k] = '0;
        for (int i = 0; i < int'(NE); i++) begin
          m_cnt[k][i] = 0;
          m_ovf[k][i] = 0;
        end
      end
    end else begin
      claimed = req_in && !ack_in && ((addr_in >> 5) == 1);
      idx     = int'(addr_in[4:0]);
      e_req   = req_in;
      e_ack   = ack_in || claimed;
      e_rd    = rd_in;
      e_addr  = addr_in;
      e_src   = src_in;
      for (int k = 0; k < 3; k++) begin
        e_data[k] = data_in;
        if (claimed && rd_in) begin
          if (idx < int'(NE)) e_data[k] = DW'(m_cnt[k][idx]);
          else                e_data[k] = 32'hDEAD_BEEF;
        end
        for (int i = 0; i < int'(NE); i++) begin
          if (claimed && idx == i && !rd_in) begin
            m_cnt[k][i] = data_in & mask_of(k);
            m_ovf[k][i] = 0;
          end else begin
            if (claimed && idx == i) begin
              m_cnt[k][i] = 0;
              m_ovf[k][i] = 0;
            end
            if (ev[i]) begin
              nxt = m_cnt[k][i] + 1;
              if (nxt > mask_of(k)) begin
                m_ovf[k][i] = 1;
                nxt = sat_of(k) ? mask_of(k) : 0;
              end else if (sat_of(k) && nxt == mask_of(k)) begin
                m_ovf[k][i] = 1;
              end
              m_cnt[k][i] = nxt;
            end
          end
        end
      end
    end
  end

  task automatic check_eq(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic compare_model();
    logic [NE-1:0] exp_ovf;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("ring_u%0d", k),
               {d_req[k], d_ack[k], d_rd[k], d_addr[k], d_data[k], d_src[k]},
               {e_req, e_ack, e_rd, e_addr, e_data[k], e_src});
      for (int i = 0; i < int'(NE); i++) exp_ovf[i] = m_ovf[k][i];
      check_eq($sformatf("ovf_u%0d", k), 64'(d_ovf[k]), 64'(exp_ovf));
    end
  endtask

  // Outputs are compared at the falling edge; inputs change just after the rising edge
  task automatic tick();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    #1;
  endtask

  task automatic ring(bit rd, int unsigned idx, logic [DW-1:0] data,
                      bit ack = 1'b0, int unsigned tag = 1);
    req_in  = 1'b1;
    ack_in  = ack;
    rd_in   = rd;
    addr_in = AW'((tag << 5) | idx);
    data_in = data;
    src_in  = SW'(idx);
    tick();
    req_in = 1'b0; ack_in = 1'b0; rd_in = 1'b0;
    addr_in = '0; data_in = '0; src_in = '0; ev = '0;
  endtask

  task automatic pulse(int i, int n);
    repeat (n) begin
      ev[i] = 1'b1;
      tick();
      ev = '0;
    end
  endtask

  initial begin
    // Events during reset are ignored
    ev = '1;
    tick();
    tick();
    ev = '0;
    check_eq("rst_ovf", 64'(d_ovf[0]), 64'h0);
    check_eq("rst_req", 64'(d_req[0]), 64'h0);
    reset = 1'b1;
    ring(1, 0, '0);
    check_eq("post_rst_rd", 64'(d_data[0]), 64'h0);
    check_eq("post_rst_ack", 64'(d_ack[0]), 64'h1);

    // Five pulses then clear-on-read
    pulse(3, 5);
    ring(1, 3, '0);
    check_eq("five_rd", 64'(d_data[0]), 64'h5);
    check_eq("five_ack", 64'(d_ack[0]), 64'h1);
    ring(1, 3, '0);
    check_eq("five_rd2", 64'(d_data[0]), 64'h0);

    // Wrap and saturate on 4-bit counters
    pulse(0, 17);
    check_eq("w4_ovf_set", 64'(d_ovf[1][0]), 64'h1);
    check_eq("s4_ovf_set", 64'(d_ovf[2][0]), 64'h1);
    check_eq("w32_ovf_clr", 64'(d_ovf[0][0]), 64'h0);
    ring(1, 0, '0);
    check_eq("w32_17", 64'(d_data[0]), 64'd17);
    check_eq("w4_wrap", 64'(d_data[1]), 64'h1);
    check_eq("s4_sat", 64'(d_data[2]), 64'hF);
    check_eq("w4_ovf_rdclr", 64'(d_ovf[1][0]), 64'h0);

    // Read coincident with an event
    pulse(2, 7);
    ev[2] = 1'b1;
    ring(1, 2, '0);
    check_eq("rd_ev_old", 64'(d_data[0]), 64'h7);
    ring(1, 2, '0);
    check_eq("rd_ev_next", 64'(d_data[0]), 64'h1);

    // Write coincident with an event, then an out-of-range index
    ev[1] = 1'b1;
    ring(0, 1, 32'h100);
    check_eq("wr_echo", 64'(d_data[0]), 64'h100);
    check_eq("wr_ack", 64'(d_ack[0]), 64'h1);
    ring(1, 1, '0);
    check_eq("wr_wins", 64'(d_data[0]), 64'h100);
    check_eq("wr_trunc4", 64'(d_data[1]), 64'h0);
    ring(1, 31, '0);
    check_eq("bad_idx_rd", 64'(d_data[0]), 64'hDEAD_BEEF);
    check_eq("bad_idx_ack", 64'(d_ack[0]), 64'h1);

    // Foreign tag and already-acked requests pass through
    ring(1, 3, 32'h1234, 1'b0, 2);
    check_eq("foreign_data", 64'(d_data[0]), 64'h1234);
    check_eq("foreign_ack", 64'(d_ack[0]), 64'h0);
    check_eq("foreign_addr", 64'(d_addr[0]), 64'h43);
    ring(1, 3, 32'hABCD, 1'b1);
    check_eq("acked_data", 64'(d_data[0]), 64'hABCD);

    // Back-to-back write then read
    ring(0, 4, 32'd9);
    ring(1, 4, '0);
    check_eq("b2b_rd", 64'(d_data[0]), 64'h9);

    // Mixed event patterns, then read every counter on consecutive cycles
    for (int c = 0; c < 20; c++) begin
      ev = NE'(c * 37 + 5);
      tick();
    end
    ev = '0;
    for (int i = 0; i < int'(NE); i++) ring(1, i, '0);

    // Reset asserted mid-request with nonzero counters
    pulse(5, 3);
    pulse(6, 2);
    req_in = 1'b1; rd_in = 1'b1; addr_in = AW'((1 << 5) | 5); src_in = 2'd1;
    tick();
    check_eq("inflight_rd", 64'(d_data[0]), 64'h3);
    #2 reset = 1'b0;
    #1;
    check_eq("async_req", 64'(d_req[0]), 64'h0);
    check_eq("async_ack", 64'(d_ack[0]), 64'h0);
    check_eq("async_data", 64'(d_data[0]), 64'h0);
    check_eq("async_addr", 64'(d_addr[0]), 64'h0);
    ev = '1;
    tick();
    req_in = 1'b0; rd_in = 1'b0; addr_in = '0; src_in = '0; ev = '0;
    reset = 1'b1;
    ring(1, 6, '0);
    check_eq("rst_cnt6", 64'(d_data[0]), 64'h0);
    ring(1, 5, '0);
    check_eq("rst_cnt5", 64'(d_data[0]), 64'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/op_lut_event_cntr_regs.md
OP_LUT_EVENT_CNTR_REGS -- requirements
Module: op_lut_event_cntr_regs

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_EVENTS, 10, number of event counters (1..32).
REQ-002 CNTR_WIDTH, 32, counter width in bits (1..32); read data zero-extended to DATA_WIDTH.
REQ-003 SATURATE, 0, 1 = counters hold at all-ones; 0 = counters wrap to 0.
REQ-004 CLEAR_ON_READ, 1, 1 = a ring read of a counter zeroes it; 0 = reads are non-destructive.
REQ-005 DATA_WIDTH, 32; REG_ADDR_WIDTH, 23; UDP_REG_SRC_WIDTH, 2: register ring field widths.
REQ-006 BLOCK_TAG, 'h1, value of reg_addr[REG_ADDR_WIDTH-1:IDX_WIDTH] that selects this block; IDX_WIDTH, 5, counter index field width.
REQ-007 Ports (name direction width meaning): clk in 1 sole clock, all logic on rising edge.
REQ-008 reset in 1 asynchronous, active-low reset.
REQ-009 reg_req_in, reg_ack_in, reg_rd_wr_L_in in 1 each; reg_addr_in in REG_ADDR_WIDTH; reg_data_in in DATA_WIDTH; reg_src_in in UDP_REG_SRC_WIDTH: upstream ring.
REQ-010 reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out out (same widths): downstream ring, all registered.
REQ-011 events in NUM_EVENTS: bit i pulsed high one cycle per event i; bits independent, any combination may be high in one cycle.
REQ-012 overflow out NUM_EVENTS: sticky flag per counter, set when counter i wraps (SATURATE=0) or first reaches all-ones (SATURATE=1).

Function
REQ-013 Ring latency SHALL be exactly one cycle: every *_out is the registered version of the corresponding *_in unless modified per REQ-014..REQ-017.
REQ-014 A request is claimed when reg_req_in=1, reg_ack_in=0 and tag field equals BLOCK_TAG; unclaimed requests and already-acked requests pass through unmodified.
REQ-015 Claimed read (reg_rd_wr_L_in=1), index < NUM_EVENTS: reg_data_out = zero-extended counter value sampled in the request cycle (before that cycle's increment), reg_ack_out=1.
REQ-016 Claimed write (reg_rd_wr_L_in=0), index < NUM_EVENTS: counter loads reg_data_in[CNTR_WIDTH-1:0], overflow[i] clears, reg_data_out = reg_data_in, reg_ack_out=1.
REQ-017 Claimed access with index >= NUM_EVENTS: read returns 'hDEAD_BEEF (truncated to DATA_WIDTH), write has no effect; reg_ack_out=1 in both cases.
REQ-018 Each cycle with events[i]=1 SHALL increment counter i by exactly 1; no event pulse is ever lost except per REQ-021.
REQ-019 SATURATE=1: counter at all-ones plus event stays all-ones. SATURATE=0: all-ones plus event becomes 0.
REQ-020 Read with CLEAR_ON_READ=1 and events[i]=1 in the same cycle: read returns old value, counter becomes 1 next cycle; same cycle without event: counter becomes 0; overflow[i] clears on that read.
REQ-021 Write and events[i]=1 in the same cycle: written value wins, that event is discarded.
REQ-022 Requests arriving on consecutive cycles SHALL each be serviced; no back-pressure exists.
REQ-023 overflow[i] setting and clearing in the same cycle: clear wins unless the post-update counter itself overflows in that cycle (never possible after a load, per REQ-021).

Reset
REQ-024 reset=0 SHALL immediately force all counters to 0, overflow to 0, and all *_out registers to 0, independent of clk.
REQ-025 A request in flight when reset asserts SHALL be dropped; after reset deasserts, the first clk edge samples the ring normally.
REQ-026 Events pulsed while reset=0 SHALL NOT be counted.

Verification
REQ-027 Pulse events[3] 5 times, read index 3 (CLEAR_ON_READ=1) -> data 5, ack 1; second read -> data 0.
REQ-028 CNTR_WIDTH=4, SATURATE=0: 17 pulses on events[0] -> read 1, overflow[0]=1 before read, 0 after; SATURATE=1 -> read 'hF.
REQ-029 Read index 2 in same cycle as events[2] with counter=7 -> data 7, subsequent read 1.
REQ-030 Write 'h100 to index 1 coincident with events[1] -> next read 'h100; read of index 31 (NUM_EVENTS=10) -> 'hDEADBEEF, ack 1.
REQ-031 Request with foreign tag, and request with reg_ack_in=1 -> passed through one cycle later, all fields unchanged.
REQ-032 Assert reset mid-request with counters nonzero -> outputs 0 asynchronously, counters read 0 after release.
